bus_arbiter4: RTL

//   Round-robin arbiter sharing the 16-bit 4:1 operand/result mux among four requesters.
//   - Grants the bus to one requester at a time and holds the grant until that requester releases it.
//   - Drives the mux select lines S1,S0, a one-hot grant vector and the muxed bus output.
//   - Sits between the requesting datapath units (ALU, load unit, PC logic, I/O) and the shared bus.

---
 rtl/bus_arbiter4.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter4.sv
// -----------------------------------------------------------------------------
// bus_arbiter4
//   Round-robin arbiter for the shared 16-bit 4:1 operand/result bus. One
//   requester owns the bus at a time and keeps it until it releases (DONE or
//   dropping REQ). On release the arbiter re-arbitrates on the same edge, so
//   the bus passes straight to the next requester with no idle bubble. The
//   previous owner is searched last.
//
//   Optional feature: define ARB_TIMEOUT_EN to enable a hold limit of MAX_HOLD
//   cycles. When the limit is reached the grant is revoked and timeout_o
//   pulses. Without the macro, grants are held indefinitely and timeout_o is 0.
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   req_i[3:0]   req_i[i]=1: requester i wants the bus
//   done_i[3:0]  done_i[i]=1: owner i releases at this edge (ignored for non-owners)
//   i0_i..i3_i   requester data inputs
//   gnt_o[3:0]   registered one-hot grant, 0 when idle
//   s1_o,s0_o    registered mux select, index of the current/last owner
//   bus_valid_o  |gnt_o
//   bus_out_o    selected data input when valid, else 0 (combinational)
//   timeout_o    one-cycle pulse when a grant was revoked by the hold limit
// -----------------------------------------------------------------------------
module bus_arbiter4 #(
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [3:0]        req_i,
  input  logic [3:0]        done_i,
  input  logic [DATA_W-1:0] i0_i,
  input  logic [DATA_W-1:0] i1_i,
  input  logic [DATA_W-1:0] i2_i,
  input  logic [DATA_W-1:0] i3_i,
  output logic [3:0]        gnt_o,
  output logic              s1_o,
  output logic              s0_o,
  output logic              bus_valid_o,
  output logic [DATA_W-1:0] bus_out_o,
  output logic              timeout_o
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter4: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       timeout_q, timeout_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  // Returns {found, index}: first set bit of mask in order last+1 .. last+4.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] c;
    r = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      c = last + k[1:0];
      if (!r[2] && mask[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  logic       rel;
  logic       tmo;
  logic       arb;
  logic [3:0] mask;
  logic [2:0] pick;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    // While BUSY, sel_q is the owner index; a normal release beats the limit.
    rel       = (state_q == BUSY) && (done_i[sel_q] || !req_i[sel_q]);
    tmo       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    if (state_q == BUSY) hold_d = hold_q + 8'd1;
    tmo       = (state_q == BUSY) && !rel && (hold_q == HOLD_LAST);
`endif
    // A timed-out owner may not win the re-arbitration it triggered.
    mask = tmo ? (req_i & ~gnt_q) : req_i;
    // last_q equals the owner while BUSY, so the owner is searched last.
    pick = rr_pick(mask, last_q);
    arb  = (state_q == IDLE) ? (|req_i) : (rel || tmo);
    if (arb) begin
      timeout_d = tmo;
      if (pick[2]) begin
        state_d = BUSY;
        gnt_d   = 4'b0001 << pick[1:0];
        sel_d   = pick[1:0];
        last_d  = pick[1:0];
`ifdef ARB_TIMEOUT_EN
        hold_d  = 8'd0;
`endif
      end else begin
        // Select lines keep the last owner so they only move with a new grant.
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      last_q    <= 2'd3;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign s1_o         = sel_q[1];
  assign s0_o         = sel_q[0];
  assign bus_valid_o  = |gnt_q;
  assign timeout_o    = timeout_q;

  always_comb begin
    bus_out_o = '0;
    if (bus_valid_o) begin
      case (sel_q)
        2'd0:    bus_out_o = i0_i;
        2'd1:    bus_out_o = i1_i;
        2'd2:    bus_out_o = i2_i;
        default: bus_out_o = i3_i;
      endcase
    end
  end

endmodule
